// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Types and constants shared by the UART transmitter and
//                receiver: frame state encoding, parity selection codes,
//                serial line levels, and the parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   // Frame sequencing states, shared with the receiver.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   // PAR_TYP encodings
   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;

   // Serial line levels
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Parity bit from the XOR reduction of the word and the parity type.
   function automatic logic parity_bit(input logic xor_red, input logic par_typ);
      return (par_typ == PAR_EVEN) ? xor_red : ~xor_red;
   endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Bit-period counter. Counts 0..i_period-1 while enabled and
//                flags the last cycle of each bit with o_bit_tick.
//  Ports       : clk          - clock
//                rst          - synchronous active-high reset
//                i_clear      - hold the counter at zero
//                i_en         - advance the counter
//                i_period     - bit period in cycles (must be >= 1)
//                o_bit_tick   - high in the last cycle of a bit period
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bit_timer #(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_clear,
   input  logic                      i_en,
   input  logic [PRESCALE_WIDTH-1:0] i_period,
   output logic                      o_bit_tick
);

   logic [PRESCALE_WIDTH-1:0] r_cnt;
   logic [PRESCALE_WIDTH-1:0] w_last;

   assign w_last     = i_period - PRESCALE_WIDTH'(1);
   assign o_bit_tick = i_en && (r_cnt == w_last);

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         // Wrap only at the end of the bit period.
         if (r_cnt == w_last) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
         end
      end
   end

endmodule : uart_bit_timer

`default_nettype wire

// File: rtl/uart_tx_prescaled.sv
// ============================================================================
//  Module      : uart_tx_prescaled
//  Description : UART transmitter clocked by the oversampling clock. Each
//                serial bit is held for Prescale cycles. Frame: start,
//                WIDTH data bits LSB first, optional parity, stop.
//  Ports       : CLK        - oversampling clock
//                RST        - synchronous active-high reset
//                P_DATA     - parallel word to send
//                Data_Valid - request strobe, accepted only when idle
//                PAR_EN     - insert a parity bit
//                PAR_TYP    - 0 even, 1 odd parity
//                Prescale   - cycles per serial bit (0 behaves as 1)
//                TX_OUT     - registered serial line, idles high
//                Busy       - high while a frame is in flight
//                Tx_Done    - one-cycle pulse after the stop bit ends
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_prescaled
   import uart_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [WIDTH-1:0]          P_DATA,
   input  logic                      Data_Valid,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   output logic                      TX_OUT,
   output logic                      Busy,
   output logic                      Tx_Done
);

   // A one-bit word still needs a one-bit counter.
   localparam int C_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(WIDTH - 1);

   uart_state_t               r_state;
   logic [WIDTH-1:0]          r_shift;
   logic [C_CNT_W-1:0]        r_bit_cnt;
   logic                      r_par_en;
   logic                      r_par_bit;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic                      r_tx;
   logic                      r_busy;
   logic                      r_done;

   logic [PRESCALE_WIDTH-1:0] w_period;
   logic [WIDTH-1:0]          w_shift_next;
   logic                      w_timer_clear;
   logic                      w_timer_en;
   logic                      w_bit_tick;

   // A latched Prescale of zero runs as a one-cycle bit.
   assign w_period      = (r_prescale == '0) ? PRESCALE_WIDTH'(1) : r_prescale;
   assign w_shift_next  = r_shift >> 1;
   assign w_timer_clear = (r_state == IDLE);
   assign w_timer_en    = (r_state != IDLE);

   uart_bit_timer #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_bit_timer (
      .clk        (CLK),
      .rst        (RST),
      .i_clear    (w_timer_clear),
      .i_en       (w_timer_en),
      .i_period   (w_period),
      .o_bit_tick (w_bit_tick)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_prescale <= '0;
         r_tx       <= LINE_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_tx   <= LINE_IDLE;
               r_busy <= 1'b0;
               if (Data_Valid) begin
                  // Snapshot everything so later input changes cannot
                  // disturb the frame.
                  r_shift    <= P_DATA;
                  r_par_en   <= PAR_EN;
                  r_par_bit  <= parity_bit(^P_DATA, PAR_TYP);
                  r_prescale <= Prescale;
                  r_bit_cnt  <= '0;
                  r_tx       <= START_BIT;
                  r_busy     <= 1'b1;
                  r_state    <= START;
               end
            end

            START: begin
               if (w_bit_tick) begin
                  r_tx      <= r_shift[0];
                  r_bit_cnt <= '0;
                  r_state   <= DATA;
               end
            end

            DATA: begin
               if (w_bit_tick) begin
                  if (r_bit_cnt == C_LAST_BIT) begin
                     if (r_par_en) begin
                        r_tx    <= r_par_bit;
                        r_state <= PARITY;
                     end else begin
                        r_tx    <= STOP_BIT;
                        r_state <= STOP;
                     end
                  end else begin
                     r_shift   <= w_shift_next;
                     r_tx      <= w_shift_next[0];
                     r_bit_cnt <= r_bit_cnt + C_CNT_W'(1);
                  end
               end
            end

            PARITY: begin
               if (w_bit_tick) begin
                  r_tx    <= STOP_BIT;
                  r_state <= STOP;
               end
            end

            STOP: begin
               if (w_bit_tick) begin
                  r_tx    <= LINE_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end

            default: begin
               r_tx    <= LINE_IDLE;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign TX_OUT  = r_tx;
   assign Busy    = r_busy;
   assign Tx_Done = r_done;

endmodule : uart_tx_prescaled

`default_nettype wire

// File: tb/tb_uart_tx_prescaled.sv
// ============================================================================
//  Module      : tb_uart_tx_prescaled
//  Description : Self-checking bench for uart_tx_prescaled. A frame model
//                builds the expected bit list from the word and settings;
//                the line is compared against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_prescaled;

   localparam int WIDTH = 8;
   localparam int PW    = 6;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [WIDTH-1:0] P_DATA = '0;
   logic          Data_Valid = 1'b0;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [PW-1:0] Prescale = '0;
   logic          TX_OUT;
   logic          Busy;
   logic          Tx_Done;

   int checks = 0;
   int errors = 0;

   // Settings for the next frame when Data_Valid is held across frames.
   logic [WIDTH-1:0] nx_data;
   logic             nx_pe;
   logic             nx_pt;
   logic [PW-1:0]    nx_ps;

   uart_tx_prescaled #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy),
      .Tx_Done    (Tx_Done)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   // Compare {TX_OUT,Busy,Tx_Done} at the current sample point.
   task automatic cmp(input string name, input int cyc, input logic [2:0] exp);
      checks++;
      if ({TX_OUT, Busy, Tx_Done} !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: {tx,busy,done} got %b expected %b",
                  name, cyc, {TX_OUT, Busy, Tx_Done}, exp);
      end
   endtask

   task automatic idle_cycles(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         cmp(name, i, 3'b100);
      end
   endtask

   task automatic start_frame(input logic [WIDTH-1:0] d, input logic pe,
                              input logic pt, input logic [PW-1:0] ps);
      @(negedge CLK);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
      @(posedge CLK);
   endtask

   // Called right after the accept edge. Checks every Busy cycle against the
   // model, then the Tx_Done cycle. inject: cycle at which a 0xFF request is
   // pulsed; hold: keep Data_Valid high with nx_* settings; abort_at: cycle
   // after which RST is raised and the task returns.
   task automatic check_frame(input string name, input logic [WIDTH-1:0] d,
                              input logic pe, input logic pt, input logic [PW-1:0] ps,
                              input int inject, input bit hold, input int abort_at);
      logic bits[$];
      int   p;
      int   len;
      bits.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < WIDTH; i++) bits.push_back(d[i]);
      if (pe) bits.push_back((^d) ^ pt);
      bits.push_back(1'b1);
      p   = (ps == 0) ? 1 : int'(ps);
      len = bits.size() * p;
      for (int c = 0; c < len; c++) begin
         @(negedge CLK);
         cmp(name, c, {bits[c / p], 2'b10});
         if (c == abort_at) begin
            RST = 1'b1;
            Data_Valid = 1'b0;
            return;
         end
         if (hold) begin
            Data_Valid = 1'b1;
            P_DATA = nx_data; PAR_EN = nx_pe; PAR_TYP = nx_pt; Prescale = nx_ps;
         end else if (c == inject) begin
            Data_Valid = 1'b1;
            P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd1;
         end else begin
            Data_Valid = 1'b0;
            P_DATA = WIDTH'($urandom); PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom); Prescale = PW'($urandom);
         end
      end
      @(negedge CLK);
      cmp({name, "_done"}, len, 3'b101);
      if (!hold) Data_Valid = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      Data_Valid = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      cmp("reset", 0, 3'b100);
      RST = 1'b0;
      Data_Valid = 1'b0;
      idle_cycles("reset_idle", 2);
   endtask

   task automatic test_plan_frames();
      start_frame(8'hA5, 1'b1, 1'b0, 6'd8);
      check_frame("a5_even_p8", 8'hA5, 1'b1, 1'b0, 6'd8, -1, 1'b0, -1);
      idle_cycles("a5_after", 2);
      start_frame(8'h3C, 1'b0, 1'b0, 6'd16);
      check_frame("3c_nopar_p16", 8'h3C, 1'b0, 1'b0, 6'd16, -1, 1'b0, -1);
      idle_cycles("3c_after", 2);
      start_frame(8'h01, 1'b1, 1'b1, 6'd4);
      check_frame("01_odd_p4", 8'h01, 1'b1, 1'b1, 6'd4, -1, 1'b0, -1);
      idle_cycles("01_after", 2);
   endtask

   task automatic test_ignore_busy();
      start_frame(8'h00, 1'b0, 1'b0, 6'd8);
      check_frame("busy_ignore", 8'h00, 1'b0, 1'b0, 6'd8, 19, 1'b0, -1);
      idle_cycles("busy_ignore_after", 5);
   endtask

   task automatic test_mid_reset();
      start_frame(8'hC3, 1'b1, 1'b0, 6'd8);
      check_frame("midrst_pre", 8'hC3, 1'b1, 1'b0, 6'd8, -1, 1'b0, 29);
      @(negedge CLK);
      RST = 1'b0;
      cmp("midrst_after", 0, 3'b100);
      idle_cycles("midrst_idle", 3);
      start_frame(8'h5A, 1'b1, 1'b1, 6'd3);
      check_frame("midrst_new", 8'h5A, 1'b1, 1'b1, 6'd3, -1, 1'b0, -1);
      idle_cycles("midrst_new_after", 1);
   endtask

   task automatic test_back_to_back();
      start_frame(8'h55, 1'b0, 1'b0, 6'd0);
      nx_data = 8'hAA; nx_pe = 1'b0; nx_pt = 1'b0; nx_ps = 6'd0;
      check_frame("b2b_55", 8'h55, 1'b0, 1'b0, 6'd0, -1, 1'b1, -1);
      check_frame("b2b_aa", 8'hAA, 1'b0, 1'b0, 6'd0, -1, 1'b0, -1);
      idle_cycles("b2b_after", 3);
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] d [0:15];
      logic             pe[0:15];
      logic             pt[0:15];
      logic [PW-1:0]    ps[0:15];
      bit               b2b[0:15];
      for (int i = 0; i < 16; i++) begin
         d[i]   = WIDTH'($urandom);
         pe[i]  = 1'($urandom);
         pt[i]  = 1'($urandom);
         ps[i]  = PW'($urandom_range(0, 7));
         b2b[i] = ($urandom_range(0, 2) == 0);
      end
      b2b[0] = 1'b0;
      start_frame(d[0], pe[0], pt[0], ps[0]);
      for (int i = 0; i < 16; i++) begin
         bit hold;
         hold = (i < 15) && b2b[i+1];
         if (hold) begin
            nx_data = d[i+1]; nx_pe = pe[i+1]; nx_pt = pt[i+1]; nx_ps = ps[i+1];
         end
         check_frame($sformatf("rand%0d", i), d[i], pe[i], pt[i], ps[i], -1, hold, -1);
         if (i < 15 && !hold) begin
            idle_cycles($sformatf("rand%0d_gap", i), 1);
            start_frame(d[i+1], pe[i+1], pt[i+1], ps[i+1]);
         end
      end
      idle_cycles("rand_end", 2);
   endtask

   initial begin
      test_reset();
      test_plan_frames();
      test_ignore_busy();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_tx_prescaled

`default_nettype wire

// File: doc/uart_tx_prescaled.md
Name: uart_tx_prescaled

Overview:
- UART transmitter that runs on the same oversampling clock as the oversampling receiver; each serial bit is held for Prescale clock cycles.
- Lets the system drive TX from the receiver's clock domain, so no separate bit-rate clock is needed.
- Accepts a parallel word with a valid strobe and emits start, data (LSB first), optional parity, and stop on TX_OUT.
- Sits beside the receiver inside the system UART top, as an alternative to the bit-clock transmitter.

Parameters:
- WIDTH, 8, data word width in bits.
- PRESCALE_WIDTH, 6, width of the Prescale input; supports bit periods up to 63 cycles.

Ports:
- CLK  input  1  oversampling clock; single clock domain.
- RST  input  1  synchronous, active-high reset.
- P_DATA  input  WIDTH  parallel word to transmit.
- Data_Valid  input  1  request strobe; accepted only when Busy=0.
- PAR_EN  input  1  1 = insert a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  PRESCALE_WIDTH  clock cycles per serial bit.
- TX_OUT  output  1  serial line, registered; idles high.
- Busy  output  1  high while a frame is in flight.
- Tx_Done  output  1  one-cycle pulse in the cycle after the stop bit ends.

Behaviour:
- Reset values:
  - On a rising CLK edge with RST=1: TX_OUT=1, Busy=0, Tx_Done=0, state=IDLE.
  - Bit counter and prescale counter are cleared; the latched word and latched configuration are discarded.
  - Reset mid-frame aborts the frame at the next edge. No partial stop bit is required.
- Accept:
  - In IDLE, if Data_Valid=1 at edge k, the block latches P_DATA, PAR_EN, PAR_TYP and Prescale.
  - From edge k+1: TX_OUT=0 (start bit) and Busy=1.
  - Input changes after accept do not affect the frame in flight.
- Data_Valid while Busy=1 is ignored: no queueing, no error.
- States:
  - IDLE -> START on accept.
  - START -> DATA after Prescale cycles.
  - DATA: WIDTH bits, LSB first, each held Prescale cycles.
  - DATA -> PARITY if latched PAR_EN=1, otherwise DATA -> STOP.
  - PARITY -> STOP after Prescale cycles.
  - STOP (TX_OUT=1) -> IDLE after Prescale cycles.
- Parity:
  - Even: bit = XOR reduction of the latched word.
  - Odd: bit = inverted XOR reduction.
  - Computed once at accept from the latched word.
- Timing:
  - Prescale counter runs 0..P-1, where P = latched Prescale.
  - A bit advances when the counter reaches P-1 and wraps to 0.
  - Latched Prescale=0 is treated as 1.
  - Frame length = (2 + WIDTH + PAR_EN) * P cycles of Busy=1.
- End of frame:
  - At the edge ending STOP: Busy=0, state=IDLE, Tx_Done=1 for exactly one cycle, TX_OUT stays 1.
  - Data_Valid sampled in that IDLE cycle is accepted, so the minimum gap between frames is one idle-high cycle.
- Outputs:
  - All outputs come directly from flops; there is no combinational path from inputs to outputs.
- Width rules:
  - Bit counter is ceil(log2(WIDTH)) bits and is compared against WIDTH-1.
  - Prescale counter is PRESCALE_WIDTH bits.
  - No counter wraps inside a bit except at P-1.

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Parity constants PAR_EVEN=0, PAR_ODD=1.
  - Line-level constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - The receiver uses the same package.
- One sub-module, uart_bit_timer:
  - Prescale counter with load/clear and a bit_tick output.
  - Reusable by the receiver's sampling logic.
- Parity and serializer logic stay in the parent.

Test Plan:
- P_DATA=0xA5, Prescale=8, PAR_EN=1, PAR_TYP=0 -> TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,0,1, each held 8 cycles. Busy high for 88 cycles; Tx_Done pulses once at cycle 89.
- P_DATA=0x3C, Prescale=16, PAR_EN=0 -> 10-bit frame 0,0,0,1,1,1,1,0,0,1. Busy high for 160 cycles; no parity slot.
- P_DATA=0x01, Prescale=4, PAR_EN=1, PAR_TYP=1 -> parity bit 0 (odd parity, one set bit). Frame = 44 cycles.
- Data_Valid with P_DATA=0xFF pulsed at cycle 20 of an in-flight 0x00 frame -> ignored; the 0x00 frame completes unchanged and no second frame starts.
- RST=1 for one edge at cycle 30 of a Prescale=8 frame -> next cycle TX_OUT=1, Busy=0, Tx_Done=0. A new Data_Valid afterwards starts a clean frame.
- Prescale=0 with Data_Valid held high for two frames (0x55, then 0xAA) -> each bit lasts 1 cycle, frames are 10 cycles long, and exactly one idle-high cycle separates the two frames.
